// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory with UART program loader (optional checksum: IMEM_CHECKSUM_EN)
module imem_loader #(
    parameter  int MEM_WORDS = 256,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pc,
    input  logic          uart_valid,
    input  logic [7:0]    uart_byte,
    output logic [31:0]   instr,
    output logic          cpu_run,
    output logic          load_error,
    output logic [AW:0]   load_words
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
`ifdef IMEM_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERR
    } state_t;

    // State entered once the data words (or an empty image) are done.
`ifdef IMEM_CHECKSUM_EN
    localparam state_t S_DONE = S_CSUM;
`else
    localparam state_t S_DONE = S_RUN;
`endif

    state_t state, state_next;

    logic [31:0] mem [MEM_WORDS];

    logic [1:0]    byte_cnt;
    logic [23:0]   byte_buf;
    logic [AW:0]   word_count;
    logic [AW-1:0] wr_addr;
    logic [31:0]   full_word;
    logic          loading;
    logic          word_done;
    logic          mem_we;
    logic [AW-1:0] rd_addr;
    logic          pc_unused;
`ifdef IMEM_CHECKSUM_EN
    logic [31:0]   csum;
`endif

    assign loading   = (state == S_LEN) || (state == S_DATA)
`ifdef IMEM_CHECKSUM_EN
                     || (state == S_CSUM)
`endif
                     ;
    assign word_done = loading && uart_valid && (byte_cnt == 2'd3);
    assign full_word = {uart_byte, byte_buf};
    assign rd_addr   = pc[AW+1:2];
    assign pc_unused = ^{pc[31:AW+2], pc[1:0]};

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        case (state)
            S_LEN: begin
                if (word_done) begin
                    if (full_word > 32'(MEM_WORDS))
                        state_next = S_ERR;
                    else if (full_word == 32'd0)
                        state_next = S_DONE;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (word_done) begin
                    mem_we = 1'b1;
                    if (load_words + (AW+1)'(1) == word_count)
                        state_next = S_DONE;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            S_CSUM: begin
                if (word_done)
                    state_next = (full_word == csum) ? S_RUN : S_ERR;
            end
`endif
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_LEN;
            byte_cnt   <= 2'd0;
            byte_buf   <= 24'd0;
            word_count <= '0;
            wr_addr    <= '0;
            load_words <= '0;
            cpu_run    <= 1'b0;
            load_error <= 1'b0;
            instr      <= NOP;
`ifdef IMEM_CHECKSUM_EN
            csum       <= 32'd0;
`endif
        end else begin
            state      <= state_next;
            cpu_run    <= (state_next == S_RUN);
            load_error <= (state_next == S_ERR);
            instr      <= (state == S_RUN) ? mem[rd_addr] : NOP;

            // Little-endian assembly: bytes shift in from the top, so the first lands in [7:0].
            if (loading && uart_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                byte_buf <= {uart_byte, byte_buf[23:8]};
            end

            if (state == S_LEN && word_done) begin
                word_count <= full_word[AW:0];
                wr_addr    <= '0;
            end

            if (mem_we) begin
                wr_addr    <= wr_addr + AW'(1);
                load_words <= load_words + (AW+1)'(1);
`ifdef IMEM_CHECKSUM_EN
                csum       <= csum + full_word;
`endif
            end
        end
    end

    // Storage has no reset: contents survive a reset mid-load.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_addr] <= full_word;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int MEM_WORDS = 256;
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef logic [7:0] byte_q_t [$];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   pc = 32'd0;
    logic          uart_valid = 1'b0;
    logic [7:0]    uart_byte = 8'd0;
    logic [31:0]   instr;
    logic          cpu_run;
    logic          load_error;
    logic [AW:0]   load_words;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    imem_loader #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst), .pc(pc),
        .uart_valid(uart_valid), .uart_byte(uart_byte),
        .instr(instr), .cpu_run(cpu_run),
        .load_error(load_error), .load_words(load_words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        uart_valid = 1'b0;
        pc = 32'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Strobes bytes on consecutive cycles, then drops the strobe.
    task automatic send_bytes(input byte_q_t q);
        foreach (q[i]) begin
            @(negedge clk);
            uart_valid = 1'b1;
            uart_byte  = q[i];
        end
        @(negedge clk);
        uart_valid = 1'b0;
    endtask

    task automatic push_word(inout byte_q_t q, input logic [31:0] w);
        for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        pc = addr;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag, instr, e);
    endtask

    initial begin
        byte_q_t q;
        logic [31:0] sum;

        do_reset();
        #1;
        chk("reset_instr", instr, NOP);
        chk("reset_cpu_run", 32'(cpu_run), 32'd0);
        chk("reset_load_error", 32'(load_error), 32'd0);
        chk("reset_load_words", 32'(load_words), 32'd0);

        // Two-word image; final byte sent separately to observe the cpu_run edge.
        q = {};
        push_word(q, 32'd2);
        push_word(q, 32'h00500093);
        push_word(q, 32'h00A00113);
`ifdef IMEM_CHECKSUM_EN
        sum = 32'h00500093 + 32'h00A00113;
        push_word(q, sum);
`else
        sum = 32'd0;
`endif
        begin
            logic [7:0] last;
            last = q.pop_back();
            send_bytes(q);
            chk("prelast_cpu_run", 32'(cpu_run), 32'd0);
            @(negedge clk);
            uart_valid = 1'b1;
            uart_byte  = last;
            chk("lastbyte_cpu_run", 32'(cpu_run), 32'd0);
            @(posedge clk);
            #1;
            uart_valid = 1'b0;
            chk("run_rise", 32'(cpu_run), 32'd1);
            chk("run_first_instr_nop", instr, NOP);
        end
        chk("a_load_words", 32'(load_words), 32'd2);
        chk("a_load_error", 32'(load_error), 32'd0);
        fetch("a_pc0", 32'd0, 32'h00500093);
        fetch("a_pc4", 32'd4, 32'h00A00113);
        fetch("a_pc_wrap", 32'(4*MEM_WORDS+3), 32'h00500093);
        fetch("a_pc5_lowbits", 32'd5, 32'h00A00113);

        q = {8'h05, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(q);
        chk("run_ignore_words", 32'(load_words), 32'd2);
        chk("run_ignore_run", 32'(cpu_run), 32'd1);
        fetch("run_ignore_pc0", 32'd0, 32'h00500093);
        fetch("run_ignore_pc4", 32'd4, 32'h00A00113);

        // Zero-length image.
        do_reset();
        #1;
        chk("rst2_cpu_run", 32'(cpu_run), 32'd0);
        q = {};
        push_word(q, 32'd0);
`ifdef IMEM_CHECKSUM_EN
        push_word(q, 32'd0);
`endif
        send_bytes(q);
        chk("zero_cpu_run", 32'(cpu_run), 32'd1);
        chk("zero_load_words", 32'(load_words), 32'd0);
        chk("zero_load_error", 32'(load_error), 32'd0);

        // Oversize length.
        do_reset();
        q = {};
        push_word(q, 32'(MEM_WORDS + 1));
        send_bytes(q);
        chk("over_load_error", 32'(load_error), 32'd1);
        chk("over_cpu_run", 32'(cpu_run), 32'd0);
        q = {8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_bytes(q);
        chk("over_sticky_error", 32'(load_error), 32'd1);
        chk("over_sticky_run", 32'(cpu_run), 32'd0);
        chk("over_load_words", 32'(load_words), 32'd0);
        fetch("over_instr_nop", 32'd0, NOP);

        // Exactly MEM_WORDS is accepted as a length.
        do_reset();
        q = {};
        push_word(q, 32'(MEM_WORDS));
        send_bytes(q);
        chk("max_len_no_error", 32'(load_error), 32'd0);
        chk("max_len_no_run", 32'(cpu_run), 32'd0);

`ifdef IMEM_CHECKSUM_EN
        do_reset();
        q = {};
        push_word(q, 32'd1);
        push_word(q, 32'h12345678);
        push_word(q, 32'h12345679);
        send_bytes(q);
        chk("csum_bad_error", 32'(load_error), 32'd1);
        chk("csum_bad_run", 32'(cpu_run), 32'd0);
        fetch("csum_bad_nop", 32'd0, NOP);
`endif

        // Reset in the middle of an image, then a fresh one-word image.
        do_reset();
        q = {8'h01, 8'h00, 8'h00, 8'h00, 8'h99, 8'h88};
        send_bytes(q);
        do_reset();
        q = {};
        push_word(q, 32'd1);
        push_word(q, 32'hDEADBEEF);
`ifdef IMEM_CHECKSUM_EN
        push_word(q, 32'hDEADBEEF);
`endif
        send_bytes(q);
        chk("mid_cpu_run", 32'(cpu_run), 32'd1);
        chk("mid_load_words", 32'(load_words), 32'd1);
        chk("mid_load_error", 32'(load_error), 32'd0);
        fetch("mid_pc0", 32'd0, 32'hDEADBEEF);
        fetch("mid_pc_wrap", 32'(4*MEM_WORDS+3), 32'hDEADBEEF);
        fetch("mid_pc4_kept", 32'd4, 32'h00A00113);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        if (sum == 32'hFFFFFFFF) $display("sum %h", sum);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction memory with a built-in UART program loader, sitting directly downstream of the fetch stage: it consumes `pc` and returns the addressed instruction word to decode. After reset it receives a length-prefixed program image as a byte stream from the UART receiver, writes it into on-chip memory, then releases the core via `cpu_run`. The top level gates the fetch stage's `PCWrite` with `cpu_run`, so `pc` holds 0 until the load completes.

## Interface
- `MEM_WORDS`, default 256: memory depth in 32-bit words; must be a power of two. `AW = $clog2(MEM_WORDS)`.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `pc`  in  32: byte address from the fetch stage.
- `uart_valid`  in  1: one-cycle strobe; `uart_byte` is valid this cycle.
- `uart_byte`  in  8: received byte.
- `instr`  out  32: registered instruction read from `mem[pc[AW+1:2]]`.
- `cpu_run`  out  1: high once the image is fully loaded; releases the fetch stage.
- `load_error`  out  1: sticky; high when the image is rejected.
- `load_words`  out  AW+1: number of words written so far.

## Operation
- FSM states: LEN, DATA, CSUM, RUN, ERR. Reset state is LEN. CSUM exists only when the checksum feature is compiled in.
- Bytes are assembled little-endian: the first byte lands in [7:0]. A 2-bit byte counter wraps 3→0 on each completed word.
- LEN: assembles 4 bytes into `word_count`.
  - If `word_count > MEM_WORDS`, go to ERR.
  - If `word_count == 0`, go to RUN (or CSUM if the checksum feature is on).
  - Otherwise go to DATA with the write address at 0.
- DATA: each completed word is written to `mem[wr_addr]`, then `wr_addr` and `load_words` increment.
  - After word `word_count-1` is written, go to RUN (or CSUM).
- CSUM: assembles 4 bytes and compares them with the running sum.
  - Match: go to RUN.
  - Mismatch: go to ERR.
- RUN: `uart_valid` is ignored. Every cycle, `instr <= mem[pc[AW+1:2]]`.
  - `pc[1:0]` is ignored.
  - `pc` bits above AW+1 are ignored, so addresses wrap modulo MEM_WORDS.
- ERR: terminal until reset. `cpu_run` stays 0, `load_error` is 1, `instr` holds NOP.
- Outside RUN, `instr` is held at 32'h00000013 (NOP).
- Memory contents are not cleared by reset. Unloaded words read undefined data and are not checked.
- Reset values:
  - `instr` = 32'h00000013
  - `cpu_run` = 0
  - `load_error` = 0
  - `load_words` = 0
  - byte counter, write address and running sum = 0
- Reset asserted mid-load: returns to LEN immediately and discards any partial word. Memory keeps whatever was already written. A new image must be sent from its length field.

## Timing
- One byte is accepted per `uart_valid` cycle. Back-to-back strobes on consecutive cycles must be handled.
- Memory write happens on the clock edge at which the 4th byte of a word is accepted.
- `cpu_run` rises on the clock edge after the last image byte is accepted. It is registered, with no combinational path from `uart_valid`.
- Read latency is 1 cycle: `instr` at edge t+1 reflects `pc` sampled at edge t.
- First-instruction timing:
  - In the first RUN cycle `pc` = 0, so `instr` = `mem[0]` one cycle later.
  - Downstream treats `instr` as valid from the second cycle `cpu_run` is high.
- `load_error` rises on the edge that accepts the offending byte: the 4th length byte or the 4th checksum byte.
- No read/write collision exists: reads only occur in RUN, writes only in DATA.

## Configuration
- `IMEM_CHECKSUM_EN` defined:
  - The image carries a trailing 4-byte little-endian checksum after the data words.
  - The checksum is the sum of all data words mod 2^32; the length word is excluded.
  - A mismatch sends the FSM to ERR.
- `IMEM_CHECKSUM_EN` undefined:
  - There is no CSUM state and no summing logic.
  - RUN is entered directly after the last data word, or directly after LEN when the count is 0.
  - `load_error` is raised only on oversize length.

## Test plan
- Load count=2, words 32'h00500093 and 32'h00A00113 (plus checksum 32'h00F001A6 if checksum enabled) → `cpu_run` rises 1 cycle after the last byte; `pc`=0 gives `instr`=32'h00500093 next cycle; `pc`=4 gives 32'h00A00113.
- Bytes 00 00 00 00 (count 0), plus checksum 00 00 00 00 if enabled → RUN with `load_words`=0 and no memory writes.
- Count = MEM_WORDS+1 (257 with the default) → `load_error`=1 on the 4th byte and `cpu_run` stays 0. Further bytes are ignored until reset.
- Checksum enabled, 1 word 32'h12345678, checksum 32'h12345679 → ERR; `instr` stays 32'h00000013.
- Reset asserted after 6 bytes of an image, then a full 1-word image 32'hDEADBEEF → RUN; `mem[0]`=32'hDEADBEEF; `load_words`=1.
- In RUN, `pc`=4*MEM_WORDS+3 (1027 with the default) → `instr`=`mem[0]` (wrap, low bits ignored). UART bytes during RUN change nothing.
